// File: rtl/intr_nch_pkg.sv
// Shared constants for the parametrised interrupt controller: register
// indices, id width and the claim-valid bit position helper.
package vc_intr_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 4;

  typedef enum logic [ADDR_W-1:0] {
    INTR_PENDING   = 4'd0,
    INTR_ENABLE    = 4'd1,
    INTR_MODE      = 4'd2,
    INTR_CLAIM     = 4'd3,
    INTR_COMPLETE  = 4'd4,
    INTR_GLOBAL    = 4'd5,
    INTR_INSERVICE = 4'd6,
    INTR_RAW       = 4'd7
  } intr_reg_e;

  // CLAIM valid flag sits in the top bit of the register word.
  function automatic int unsigned claim_valid_bit(input int unsigned rv);
    return rv - 1;
  endfunction

endpackage

// File: rtl/intr_nch_sync.sv
// Two-flop synchroniser for one interrupt line, with a delayed copy for
// rising-edge detection.
module intr_sync (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic level,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = src;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q;

endmodule

// File: rtl/intr_nch.sv
// Interrupt controller for up to 15 sources: per-source sync, level/edge
// pending, enable, fixed-priority claim/complete and a registered CPU request.
module intr_nch
  import vc_intr_pkg::*;
#(
  parameter int unsigned NSRC = 3,
  parameter int unsigned RV   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   src,
  output logic              interrupt,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic              io_write,
  input  logic              io_read,
  input  logic [RV-1:0]     io_wdata,
  output logic [RV-1:0]     io_rdata
);

  localparam int unsigned CLAIM_BIT = claim_valid_bit(RV);

  logic [NSRC-1:0] raw, rise;

  for (genvar g = 0; g < int'(NSRC); g++) begin : g_sync
    intr_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .src   (src[g]),
      .level (raw[g]),
      .rise  (rise[g])
    );
  end

  logic [NSRC-1:0] en_q, en_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] insvc_q, insvc_d;
  logic [NSRC-1:0] epend_q, epend_d;
  logic            glob_q, glob_d;
  logic            int_q, int_d;

  logic [NSRC-1:0] pend, elig, claim_oh, cmp_oh, w1c, wdata_n;
  logic [ID_W-1:0] claim_id, cmp_id;
  logic            claim_valid, claim_fire, cmp_ok;
  logic            unused_wdata;

  // Level sources expose the synchronised line; edge sources the sticky flop.
  assign pend    = (mode_q & epend_q) | (~mode_q & raw);
  assign elig    = pend & en_q & ~insvc_q;
  assign wdata_n = io_wdata[NSRC-1:0];
  assign cmp_id  = io_wdata[ID_W-1:0];
  assign unused_wdata = ^io_wdata;

  // Fixed priority: lowest index wins.
  always_comb begin
    claim_id = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (elig[i]) claim_id = ID_W'(i);
    end
  end

  always_comb begin
    claim_oh = '0;
    cmp_oh   = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      claim_oh[i] = (claim_id == ID_W'(i));
      cmp_oh[i]   = (cmp_id == ID_W'(i));
    end
  end

  assign claim_valid = |elig;
  assign claim_fire  = io_read & ~io_write & (io_addr == INTR_CLAIM) & claim_valid;
  assign cmp_ok      = 32'(cmp_id) < NSRC;

  always_comb begin
    en_d    = en_q;
    mode_d  = mode_q;
    insvc_d = insvc_q;
    glob_d  = glob_q;
    w1c     = '0;
    int_d   = glob_q & |elig;
    if (io_write) begin
      case (io_addr)
        INTR_PENDING:  w1c = wdata_n & mode_q;
        INTR_ENABLE:   en_d = wdata_n;
        INTR_MODE:     mode_d = wdata_n;
        INTR_COMPLETE: if (cmp_ok) insvc_d = insvc_q & ~cmp_oh;
        INTR_GLOBAL:   glob_d = io_wdata[0];
        default:       ;
      endcase
    end else if (claim_fire) begin
      insvc_d = insvc_q | claim_oh;
      w1c     = claim_oh & mode_q;
    end
    // A new edge in the same cycle as a clear keeps the bit set.
    epend_d = (epend_q & ~w1c) | (rise & mode_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q    <= '0;
      mode_q  <= '0;
      insvc_q <= '0;
      epend_q <= '0;
      glob_q  <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      en_q    <= en_d;
      mode_q  <= mode_d;
      insvc_q <= insvc_d;
      epend_q <= epend_d;
      glob_q  <= glob_d;
      int_q   <= int_d;
    end
  end

  assign interrupt = int_q;

  always_comb begin
    io_rdata = '0;
    case (io_addr)
      INTR_PENDING:   io_rdata = RV'(pend);
      INTR_ENABLE:    io_rdata = RV'(en_q);
      INTR_MODE:      io_rdata = RV'(mode_q);
      INTR_CLAIM: begin
        if (claim_valid) begin
          io_rdata[CLAIM_BIT]  = 1'b1;
          io_rdata[ID_W-1:0]   = claim_id;
        end
      end
      INTR_GLOBAL:    io_rdata = RV'(glob_q);
      INTR_INSERVICE: io_rdata = RV'(insvc_q);
      INTR_RAW:       io_rdata = RV'(raw);
      default:        io_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_intr_nch.sv
// Scoreboard bench for intr_nch: expected register reads are queued as each
// bus access is driven and popped when the read data is sampled.
module tb_intr_nch;

  localparam int unsigned NSRC = 3;
  localparam int unsigned RV   = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] src;
  logic            interrupt;
  logic [3:0]      io_addr;
  logic            io_write;
  logic            io_read;
  logic [RV-1:0]   io_wdata;
  logic [RV-1:0]   io_rdata;

  int total = 0;
  int bad   = 0;

  logic [RV-1:0] exp_q[$];
  string         tag_q[$];

  intr_nch #(.NSRC(NSRC), .RV(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .src       (src),
    .interrupt (interrupt),
    .io_addr   (io_addr),
    .io_write  (io_write),
    .io_read   (io_read),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One bus read; strobe=1 fires the CLAIM side effect at the following edge.
  task automatic bus_rd(input string tag, input logic [3:0] a, input logic strobe,
                        input logic [RV-1:0] exp);
    @(negedge clk);
    io_addr  = a;
    io_read  = strobe;
    io_write = 1'b0;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    check(tag_q.pop_front(), 32'(io_rdata), 32'(exp_q.pop_front()));
    @(negedge clk);
    io_read = 1'b0;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [RV-1:0] d);
    @(negedge clk);
    io_addr  = a;
    io_wdata = d;
    io_write = 1'b1;
    io_read  = 1'b0;
    @(negedge clk);
    io_write = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [NSRC-1:0] m);
    @(negedge clk);
    src = m;
    cyc(2);
    src = '0;
    cyc(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    src      = 3'b111;
    io_addr  = '0;
    io_write = 1'b0;
    io_read  = 1'b0;
    io_wdata = '0;
    cyc(3);

    // Reset state: every index reads 0 while held in reset.
    for (int a = 0; a < 16; a++) bus_rd("rst_rd", 4'(a), 1'b0, 16'h0000);
    check("rst_irq", 32'(interrupt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(4);
    bus_rd("raw_after_rst", 4'd7, 1'b0, 16'h0007);
    src = '0;
    cyc(4);

    // Level source 1.
    bus_wr(4'd2, 16'h0000);
    bus_wr(4'd1, 16'h0002);
    bus_wr(4'd5, 16'h0001);
    cyc(2);
    check("lvl_idle_irq", 32'(interrupt), 32'd0);
    src[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 check("lvl_irq_e1", 32'(interrupt), 32'd0);
    @(posedge clk);
    #1 check("lvl_irq_e2", 32'(interrupt), 32'd1);
    bus_rd("lvl_claim", 4'd3, 1'b1, 16'h8001);
    check("lvl_irq_claim_edge", 32'(interrupt), 32'd1);
    @(posedge clk);
    #1 check("lvl_irq_drop", 32'(interrupt), 32'd0);
    bus_rd("lvl_insvc", 4'd6, 1'b0, 16'h0002);
    bus_wr(4'd4, 16'h0001);
    check("lvl_irq_cmp_edge", 32'(interrupt), 32'd0);
    @(posedge clk);
    #1 check("lvl_irq_reassert", 32'(interrupt), 32'd1);
    @(negedge clk);
    src = '0;
    cyc(4);
    check("lvl_irq_release", 32'(interrupt), 32'd0);

    // Edge sources 0 and 2, priority order.
    bus_wr(4'd2, 16'h0007);
    bus_wr(4'd1, 16'h0007);
    pulse(3'b101);
    bus_rd("edge_pend", 4'd0, 1'b0, 16'h0005);
    check("edge_irq", 32'(interrupt), 32'd1);
    bus_rd("edge_claim0", 4'd3, 1'b1, 16'h8000);
    bus_rd("edge_claim2", 4'd3, 1'b1, 16'h8002);
    bus_rd("edge_claim_none", 4'd3, 1'b1, 16'h0000);
    bus_rd("edge_insvc", 4'd6, 1'b0, 16'h0005);
    bus_rd("edge_pend_clr", 4'd0, 1'b0, 16'h0000);
    check("edge_irq_off", 32'(interrupt), 32'd0);
    bus_wr(4'd4, 16'h0000);
    bus_wr(4'd4, 16'h0002);
    bus_rd("edge_insvc_clr", 4'd6, 1'b0, 16'h0000);

    // Edge latency on source 1.
    @(negedge clk);
    src[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 check("edge_irq_e2", 32'(interrupt), 32'd0);
    @(posedge clk);
    #1 check("edge_irq_e3", 32'(interrupt), 32'd1);
    @(negedge clk);
    src = '0;
    bus_rd("edge_claim1", 4'd3, 1'b1, 16'h8001);
    bus_wr(4'd4, 16'h0001);

    // W1C racing a new rising edge on source 0.
    pulse(3'b001);
    bus_rd("race_pend_pre", 4'd0, 1'b0, 16'h0001);
    @(negedge clk);
    src[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    io_addr  = 4'd0;
    io_wdata = 16'h0001;
    io_write = 1'b1;
    @(negedge clk);
    io_write = 1'b0;
    bus_rd("race_pend_kept", 4'd0, 1'b0, 16'h0001);
    bus_wr(4'd0, 16'h0001);
    bus_rd("w1c_clears", 4'd0, 1'b0, 16'h0000);
    @(negedge clk);
    src = '0;
    cyc(4);

    // Ignored COMPLETE writes.
    pulse(3'b001);
    bus_rd("cmp_claim0", 4'd3, 1'b1, 16'h8000);
    bus_wr(4'd4, 16'h0009);
    bus_rd("cmp9_insvc", 4'd6, 1'b0, 16'h0001);
    bus_rd("cmp9_enable", 4'd1, 1'b0, 16'h0007);
    bus_rd("cmp9_mode", 4'd2, 1'b0, 16'h0007);
    bus_rd("cmp9_global", 4'd5, 1'b0, 16'h0001);
    bus_wr(4'd4, 16'h0002);
    bus_rd("cmp_idle_insvc", 4'd6, 1'b0, 16'h0001);
    bus_wr(4'd4, 16'h0000);
    bus_rd("cmp0_insvc", 4'd6, 1'b0, 16'h0000);

    // Reset on the same edge as a CLAIM strobe.
    pulse(3'b100);
    bus_rd("rc_pend_pre", 4'd0, 1'b0, 16'h0004);
    @(negedge clk);
    io_addr = 4'd3;
    io_read = 1'b1;
    reset   = 1'b0;
    @(negedge clk);
    io_read = 1'b0;
    reset   = 1'b1;
    bus_rd("rc_insvc", 4'd6, 1'b0, 16'h0000);
    bus_rd("rc_pend", 4'd0, 1'b0, 16'h0000);
    bus_rd("rc_enable", 4'd1, 1'b0, 16'h0000);
    check("rc_irq", 32'(interrupt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
